// File: rtl/mem_access_ctrl.sv
// Round-robin two-port sequencer for the 8x8 latch memory (setup/strobe/hold).
// Define MEM_WRITE_VERIFY_EN to add a read-back check after every write.
module mem_access_ctrl #(
  parameter int STROBE_CYCLES = 1,
  parameter int DATA_W        = 8,
  parameter int ADDR_W        = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic              mem_op,
  output logic              mem_select,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_in_bus,
  input  logic [DATA_W-1:0] mem_out_bus,
`ifdef MEM_WRITE_VERIFY_EN
  output logic              rsp0_err,
  output logic              rsp1_err,
`endif
  output logic              busy
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] SETUP   = 3'd1;
  localparam logic [2:0] STROBE  = 3'd2;
  localparam logic [2:0] HOLD    = 3'd3;
`ifdef MEM_WRITE_VERIFY_EN
  localparam logic [2:0] VSETUP  = 3'd4;
  localparam logic [2:0] VSTROBE = 3'd5;
  localparam logic [2:0] VHOLD   = 3'd6;
`endif

  localparam logic [3:0] CNT_LAST = 4'(STROBE_CYCLES - 1);

  logic [2:0]        state;
  logic [3:0]        cnt;
  logic              last_grant;
  logic              gnt_q;
  logic              we_q;
  logic              op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata1_q;
  logic              gnt0;
  logic              gnt1;
  logic              accept;
  logic              rsp_fire;
`ifdef MEM_WRITE_VERIFY_EN
  logic [DATA_W-1:0] vdata_q;
  logic              err_fire;
`endif

  // Contention goes to whichever requester did not win last time.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state == IDLE) begin
      gnt0 = req0_valid && (!req1_valid || last_grant);
      gnt1 = req1_valid && (!req0_valid || !last_grant);
    end
  end

  assign accept     = gnt0 | gnt1;
  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  assign busy       = (state != IDLE);
  assign mem_op     = op_q;
  assign mem_addr   = addr_q;
  assign mem_in_bus = wdata_q;
  assign rsp0_rdata = rdata0_q;
  assign rsp1_rdata = rdata1_q;

`ifdef MEM_WRITE_VERIFY_EN
  assign mem_select = (state == STROBE) || (state == VSTROBE);
`else
  assign mem_select = (state == STROBE);
`endif

  always_comb begin
    rsp_fire = 1'b0;
`ifdef MEM_WRITE_VERIFY_EN
    err_fire = 1'b0;
    if (state == HOLD && !we_q) rsp_fire = 1'b1;
    if (state == VHOLD) begin
      rsp_fire = 1'b1;
      err_fire = (vdata_q != wdata_q);
    end
`else
    if (state == HOLD) rsp_fire = 1'b1;
`endif
  end

  assign rsp0_valid = rsp_fire && !gnt_q;
  assign rsp1_valid = rsp_fire && gnt_q;
`ifdef MEM_WRITE_VERIFY_EN
  assign rsp0_err = err_fire && !gnt_q;
  assign rsp1_err = err_fire && gnt_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      last_grant <= 1'b1;
      gnt_q      <= 1'b0;
      we_q       <= 1'b0;
      op_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
`ifdef MEM_WRITE_VERIFY_EN
      vdata_q    <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            state      <= SETUP;
            gnt_q      <= gnt1;
            last_grant <= gnt1;
            we_q       <= gnt1 ? req1_we : req0_we;
            op_q       <= gnt1 ? req1_we : req0_we;
            addr_q     <= gnt1 ? req1_addr : req0_addr;
            wdata_q    <= gnt1 ? req1_wdata : req0_wdata;
          end
        end
        SETUP: begin
          state <= STROBE;
          cnt   <= CNT_LAST;
        end
        STROBE: begin
          if (cnt == 4'd0) begin
            state <= HOLD;
            if (!we_q && !gnt_q) rdata0_q <= mem_out_bus;
            if (!we_q && gnt_q)  rdata1_q <= mem_out_bus;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
`ifdef MEM_WRITE_VERIFY_EN
        HOLD: begin
          if (we_q) begin
            state <= VSETUP;
            op_q  <= 1'b0;
          end else begin
            state <= IDLE;
          end
        end
        VSETUP: begin
          state <= VSTROBE;
          cnt   <= CNT_LAST;
        end
        VSTROBE: begin
          if (cnt == 4'd0) begin
            state   <= VHOLD;
            vdata_q <= mem_out_bus;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        VHOLD: state <= IDLE;
`else
        HOLD: state <= IDLE;
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl with a behavioural memory and model.
// Covers MEM_WRITE_VERIFY_EN when the macro is defined.
module tb_mem_access_ctrl;

  localparam int S = 1;
`ifdef MEM_WRITE_VERIFY_EN
  localparam bit VER = 1'b1;
`else
  localparam bit VER = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0_valid = 0, req0_we = 0;
  logic [2:0] req0_addr = 0;
  logic [7:0] req0_wdata = 0;
  logic       req1_valid = 0, req1_we = 0;
  logic [2:0] req1_addr = 0;
  logic [7:0] req1_wdata = 0;
  logic       req0_ready, req1_ready, rsp0_valid, rsp1_valid;
  logic [7:0] rsp0_rdata, rsp1_rdata;
  logic       mem_op, mem_select, busy;
  logic [2:0] mem_addr;
  logic [7:0] mem_in_bus, mem_out_bus;
`ifdef MEM_WRITE_VERIFY_EN
  logic       rsp0_err, rsp1_err;
`endif

  mem_access_ctrl #(.STROBE_CYCLES(S), .DATA_W(8), .ADDR_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .mem_op(mem_op), .mem_select(mem_select), .mem_addr(mem_addr),
    .mem_in_bus(mem_in_bus), .mem_out_bus(mem_out_bus),
`ifdef MEM_WRITE_VERIFY_EN
    .rsp0_err(rsp0_err), .rsp1_err(rsp1_err),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Memory array seen by the DUT's pins.
  logic [7:0] mem_arr [8];
  logic       mem_clr = 1'b1;
  logic       force_zero = 1'b0;
  int         cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_clr) begin
      for (int i = 0; i < 8; i++) mem_arr[i] <= 8'h00;
    end else if (mem_select && mem_op) begin
      mem_arr[mem_addr] <= mem_in_bus;
    end
  end

  assign mem_out_bus = force_zero ? 8'h00 : mem_arr[mem_addr];

  // Reference state.
  logic [7:0] ref_mem [8];
  logic [7:0] last_rd [2];
  bit         exp_last;
  int         errors = 0;
  int         checks = 0;

  typedef struct {
    bit         id;
    bit         we;
    logic [2:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [18];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic rdy(input bit id);
    return id ? req1_ready : req0_ready;
  endfunction

  function automatic logic rspv(input bit id);
    return id ? rsp1_valid : rsp0_valid;
  endfunction

  function automatic logic [7:0] rspd(input bit id);
    return id ? rsp1_rdata : rsp0_rdata;
  endfunction

  task automatic drive(input bit id, input bit v, input bit we,
                       input logic [2:0] a, input logic [7:0] d);
    if (id) begin
      req1_valid = v; req1_we = we; req1_addr = a; req1_wdata = d;
    end else begin
      req0_valid = v; req0_we = we; req0_addr = a; req0_wdata = d;
    end
  endtask

  task automatic do_access(input bit id, input bit we, input logic [2:0] a,
                           input logic [7:0] wd, input logic [7:0] ex);
    int  n;
    int  rk;
    bit  sel_exp;
    bit  main_sel;
    bit  exp_err;
    exp_err = VER && we && force_zero && (wd != 8'h00);
    @(posedge clk); #1;
    drive(id, 1'b1, we, a, wd);
    n = 0;
    @(negedge clk);
    while (!rdy(id) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", rdy(id), 1);
    chk("other_ready", rdy(!id), 0);
    @(posedge clk); #1;
    drive(id, 1'b0, we, a, wd);
    rk = 2 + S + ((VER && we) ? S + 2 : 0);
    for (int k = 1; k <= rk; k++) begin
      @(negedge clk);
      main_sel = (k >= 2) && (k <= 1 + S);
      sel_exp  = main_sel || (VER && we && k >= 4 + S && k <= 3 + 2 * S);
      chk("mem_select", mem_select, sel_exp);
      if (main_sel) begin
        chk("mem_addr", mem_addr, a);
        chk("mem_op", mem_op, we);
        if (we) chk("mem_in_bus", mem_in_bus, wd);
      end
      chk("rsp_valid", rspv(id), k == rk);
      chk("rsp_other", rspv(!id), 0);
      if (k == rk) begin
        if (!we) chk("rsp_rdata", rspd(id), ex);
        else     chk("rdata_held", rspd(id), last_rd[id]);
`ifdef MEM_WRITE_VERIFY_EN
        chk("rsp_err", id ? rsp1_err : rsp0_err, exp_err);
`endif
      end
    end
    if (we) ref_mem[a] = wd;
    else    last_rd[id] = ex;
    exp_last = id;
  endtask

  initial begin
    int n;
    int prev;
    bit w;
    bit id;
    bit we;
    logic [2:0] a;
    logic [7:0] d;

    for (int i = 0; i < 8; i++) ref_mem[i] = 8'h00;
    last_rd[0] = 8'h00;
    last_rd[1] = 8'h00;
    exp_last = 1'b1;

    vecs[0] = '{id: 0, we: 1, addr: 3, wdata: 8'hA5, exp: 8'h00};
    vecs[1] = '{id: 1, we: 0, addr: 3, wdata: 8'h00, exp: 8'hA5};
    for (int i = 0; i < 8; i++) begin
      vecs[2 + i]  = '{id: i[0], we: 1, addr: 3'(i),
                       wdata: 8'(8'h11 * (i + 1)), exp: 8'h00};
      vecs[10 + i] = '{id: !i[0], we: 0, addr: 3'(i),
                       wdata: 8'h00, exp: 8'(8'h11 * (i + 1))};
    end

    // Reset state
    @(posedge clk); #2;
    chk("rst_busy", busy, 0);
    chk("rst_select", mem_select, 0);
    chk("rst_op", mem_op, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_in_bus", mem_in_bus, 0);
    chk("rst_rsp", {rsp0_valid, rsp1_valid}, 0);
    chk("rst_rdata", {rsp0_rdata, rsp1_rdata}, 0);
    chk("rst_ready", {req0_ready, req1_ready}, 0);
    @(negedge clk);
    mem_clr = 1'b0;
    rst_n   = 1'b1;

    for (int i = 0; i < 18; i++)
      do_access(vecs[i].id, vecs[i].we, vecs[i].addr,
                vecs[i].wdata, vecs[i].exp);

    for (int i = 0; i < 40; i++) begin
      id = 1'($urandom_range(0, 1));
      we = 1'($urandom_range(0, 1));
      a  = 3'($urandom_range(0, 7));
      d  = 8'($urandom_range(0, 255));
      do_access(id, we, a, d, ref_mem[a]);
    end

    // Reset in the middle of a write strobe
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b1, 3'd3, ref_mem[3]);
    @(negedge clk);
    chk("abort_accept", req0_ready, 1);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b1, 3'd3, ref_mem[3]);
    @(posedge clk); #1;
    chk("abort_strobe", mem_select, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_select", mem_select, 0);
    chk("abort_busy", busy, 0);
    chk("abort_rsp", rsp0_valid, 0);
    chk("abort_addr", mem_addr, 0);
    chk("abort_rdata", rsp0_rdata, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    last_rd[0] = 8'h00;
    last_rd[1] = 8'h00;
    exp_last = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("abort_no_rsp", {rsp0_valid, rsp1_valid}, 0);
    end
    do_access(1, 1'b0, 3'd3, 8'h00, ref_mem[3]);

    // Continuous contention alternates grants
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b0, 3'd1, 8'h00);
    drive(1, 1'b1, 1'b0, 3'd2, 8'h00);
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      @(negedge clk);
      while (!(req0_ready || req1_ready) && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("cont_one_ready", req0_ready && req1_ready, 0);
      chk("cont_any_ready", req0_ready || req1_ready, 1);
      w = req1_ready;
      chk("cont_grant", w, !exp_last);
      exp_last = !exp_last;
      if (i > 0) chk("cont_spacing", cyc - prev, S + 3);
      prev = cyc;
      @(posedge clk);
    end
    #1;
    drive(0, 1'b0, 1'b0, 3'd1, 8'h00);
    drive(1, 1'b0, 1'b0, 3'd2, 8'h00);
    n = 0;
    @(negedge clk);
    while (busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("cont_drain", busy, 0);
    exp_last = 1'b1;
    last_rd[1] = ref_mem[2];
    last_rd[0] = ref_mem[1];
    do_access(0, 1'b0, 3'd1, 8'h00, ref_mem[1]);

`ifdef MEM_WRITE_VERIFY_EN
    force_zero = 1'b1;
    do_access(0, 1'b1, 3'd4, 8'h5A, 8'h00);
    force_zero = 1'b0;
    do_access(0, 1'b1, 3'd4, 8'h5A, 8'h00);
    do_access(1, 1'b0, 3'd4, 8'h00, ref_mem[4]);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
